// File: rtl/pc_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pc_gen_pkg                                                |
// | Brief    : Shared constants and state encoding for the fetch PC gen. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package pc_gen_pkg;

  localparam int unsigned          c_INST_W   = 32;
  localparam logic [c_INST_W-1:0]  c_RESET_PC = 32'h1c00_0000;

  localparam logic [1:0] c_ST_IDLE = 2'b00;
  localparam logic [1:0] c_ST_REQ  = 2'b01;
  localparam logic [1:0] c_ST_RESP = 2'b10;
  localparam logic [1:0] c_ST_DROP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = c_ST_IDLE,
    ST_REQ  = c_ST_REQ,
    ST_RESP = c_ST_RESP,
    ST_DROP = c_ST_DROP
  } pc_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pc_gen_if                                                 |
// | Brief    : Instruction-memory request/grant/response bus.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface pc_gen_if;
  import pc_gen_pkg::*;

  logic                req;
  logic [c_INST_W-1:0] addr;
  logic                gnt;
  logic                rvalid;
  logic [c_INST_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pc_gen                                                    |
// | Brief    : Fetch PC generator, one outstanding IROM request, branch  |
// |            redirect, registered fetch packet to decode.              |
// |            Optional: PC_GEN_ADEF_CHECK_EN adds misaligned-target trap.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [c_INST_W-1:0] RESET_PC = c_RESET_PC
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall,
  input  logic                br_valid,
  input  logic                br_taken,
  input  logic [c_INST_W-1:0] br_target,
  pc_gen_if.master            irom,
  output logic                if_valid,
  output logic [c_INST_W-1:0] if_pc,
  output logic [c_INST_W-1:0] if_inst,
`ifdef PC_GEN_ADEF_CHECK_EN
  output logic                adef,
`endif
  output logic                flush
);

  pc_state_e           r_state;
  pc_state_e           w_state_nxt;
  logic [c_INST_W-1:0] r_pc;
  logic [c_INST_W-1:0] w_pc_nxt;
  logic [c_INST_W-1:0] w_pc_inc;
  logic [c_INST_W-1:0] w_target;
  logic                w_redirect;
  logic                w_misaligned;
  logic                w_halted;
  logic                w_slot_busy;
  logic                w_req;
  logic                w_capture;

  logic                r_if_valid;
  logic [c_INST_W-1:0] r_if_pc;
  logic [c_INST_W-1:0] r_if_inst;
  logic                r_buf_valid;
  logic [c_INST_W-1:0] r_buf_pc;
  logic [c_INST_W-1:0] r_buf_inst;

  assign w_redirect  = br_valid & br_taken;
  assign w_pc_inc    = r_pc + 32'd4;
  assign w_slot_busy = r_if_valid & stall;
  // A parked word in the skid register blocks new requests until decode drains.
  assign w_req       = (r_state == ST_REQ) & ~w_slot_busy & ~r_buf_valid;

`ifdef PC_GEN_ADEF_CHECK_EN
  logic r_adef;

  assign w_target     = br_target;
  assign w_misaligned = w_redirect & (br_target[1:0] != 2'b00);
  assign w_halted     = r_adef;
  assign adef         = r_adef;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_adef <= 1'b0;
    end else if (w_redirect) begin
      r_adef <= w_misaligned;
    end
  end
`else
  assign w_target     = br_target & {{(c_INST_W-2){1'b1}}, 2'b00};
  assign w_misaligned = 1'b0;
  assign w_halted     = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    if (w_misaligned) begin
      w_state_nxt = ST_IDLE;
      w_pc_nxt    = w_target;
    end else if (w_redirect) begin
      // Any grant or response for the old stream is dropped here.
      w_pc_nxt = w_target;
      case (r_state)
        ST_RESP: w_state_nxt = irom.rvalid ? ST_REQ : ST_DROP;
        ST_DROP: w_state_nxt = irom.rvalid ? ST_REQ : ST_DROP;
        default: w_state_nxt = ST_REQ;
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_halted) begin
            w_state_nxt = ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_req && irom.gnt) begin
            w_state_nxt = ST_RESP;
          end
        end
        ST_RESP: begin
          if (irom.rvalid) begin
            w_capture   = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = ST_REQ;
          end
        end
        ST_DROP: begin
          if (irom.rvalid) begin
            w_state_nxt = ST_REQ;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Decode owns the slot while if_valid & stall; a word landing then is parked.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_if_valid  <= 1'b0;
      r_if_pc     <= '0;
      r_if_inst   <= '0;
      r_buf_valid <= 1'b0;
      r_buf_pc    <= '0;
      r_buf_inst  <= '0;
    end else if (w_redirect) begin
      r_if_valid  <= 1'b0;
      r_buf_valid <= 1'b0;
    end else if (w_capture) begin
      if (w_slot_busy) begin
        r_buf_valid <= 1'b1;
        r_buf_pc    <= r_pc;
        r_buf_inst  <= irom.rdata;
      end else begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_pc;
        r_if_inst  <= irom.rdata;
      end
    end else if (!w_slot_busy) begin
      r_if_valid  <= r_buf_valid;
      r_buf_valid <= 1'b0;
      if (r_buf_valid) begin
        r_if_pc   <= r_buf_pc;
        r_if_inst <= r_buf_inst;
      end
    end
  end

  assign irom.req  = w_req;
  assign irom.addr = r_pc;
  assign flush     = w_redirect;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pc_gen                                                 |
// | Brief    : Scoreboard bench for pc_gen with a latency-programmable   |
// |            IROM model (PC_GEN_ADEF_CHECK_EN adds the adef scenario). |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam logic [31:0] c_BOOT = 32'h1c00_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pkt_t;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        flush;
`ifdef PC_GEN_ADEF_CHECK_EN
  logic        adef;
`endif

  pc_gen_if irom ();

  pc_gen #(.RESET_PC(c_BOOT)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .stall    (stall),
    .br_valid (br_valid),
    .br_taken (br_taken),
    .br_target(br_target),
    .irom     (irom),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
`ifdef PC_GEN_ADEF_CHECK_EN
    .adef     (adef),
`endif
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  pkt_t        sb[$];
  int          lat;
  int          mem_wait;
  logic        gnt_en;
  logic        mem_pend;
  logic        mem_kill;
  logic        stale_inj;
  logic [31:0] mem_addr;
  logic [31:0] exp_next;
  logic [31:0] last_addr;
  logic        last_gnt;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return ~a ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [31:0] aligned(input logic [31:0] t);
`ifdef PC_GEN_ADEF_CHECK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic tick();
    logic        req_s;
    logic        gnt_s;
    logic        redir_s;
    logic        busy_s;
    logic        rv_now;
    logic [31:0] addr_s;
    logic [31:0] tgt_s;
    pkt_t        p;
    last_gnt    = 1'b0;
    rv_now      = 1'b0;
    irom.rvalid = 1'b0;
    irom.rdata  = 32'h0;
    irom.gnt    = gnt_en;
    if (mem_pend && mem_wait == 0) begin
      irom.rvalid = 1'b1;
      irom.rdata  = word_of(mem_addr);
      rv_now      = 1'b1;
    end
    if (stale_inj) begin
      irom.rvalid = 1'b1;
      irom.rdata  = 32'hdead_beef;
      stale_inj   = 1'b0;
    end
    #1;
    req_s   = irom.req;
    gnt_s   = gnt_en;
    addr_s  = irom.addr;
    redir_s = br_valid & br_taken;
    tgt_s   = br_target;
    busy_s  = if_valid & stall;
    check("flush", {31'd0, flush}, {31'd0, redir_s});
    if (busy_s) check("req_in_stall", {31'd0, irom.req}, 32'd0);
    if (if_valid && !stall && !redir_s) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        p = sb.pop_front();
        check("if_pc", if_pc, p.pc);
        check("if_inst", if_inst, p.inst);
      end
    end
    @(posedge clk);
    #1;
    if (redir_s) begin
      sb.delete();
      exp_next = aligned(tgt_s);
      if (mem_pend) mem_kill = 1'b1;
    end
    if (rv_now) begin
      mem_pend = 1'b0;
      if (!mem_kill && !redir_s) begin
        sb.push_back('{pc: mem_addr, inst: word_of(mem_addr)});
        if (!busy_s) begin
          check("lat_valid", {31'd0, if_valid}, 32'd1);
          check("lat_pc", if_pc, mem_addr);
        end
      end
      mem_kill = 1'b0;
    end else if (mem_pend && mem_wait > 0) begin
      mem_wait--;
    end
    if (req_s && gnt_s && !redir_s) begin
      check("irom_addr", addr_s, exp_next);
      exp_next  = addr_s + 32'd4;
      mem_pend  = 1'b1;
      mem_kill  = 1'b0;
      mem_addr  = addr_s;
      mem_wait  = lat - 1;
      last_addr = addr_s;
      last_gnt  = 1'b1;
    end
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_gnt && n < 60);
    if (!last_gnt) check("grant_timeout", {31'd0, last_gnt}, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    br_target = tgt;
    tick();
    br_valid  = 1'b0;
    br_taken  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn        = 1'b0;
    stall       = 1'b0;
    br_valid    = 1'b0;
    br_taken    = 1'b0;
    br_target   = 32'h0;
    gnt_en      = 1'b1;
    lat         = 1;
    mem_wait    = 0;
    mem_pend    = 1'b0;
    mem_kill    = 1'b0;
    stale_inj   = 1'b0;
    mem_addr    = 32'h0;
    last_addr   = 32'h0;
    last_gnt    = 1'b0;
    exp_next    = c_BOOT;
    irom.gnt    = 1'b0;
    irom.rvalid = 1'b0;
    irom.rdata  = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_req", {31'd0, irom.req}, 32'd0);

    // Release: IDLE for one edge, then the first request at the boot address.
    rstn = 1'b1;
    #1;
    check("req_idle", {31'd0, irom.req}, 32'd0);
    tick();
    check("req_first", {31'd0, irom.req}, 32'd1);
    check("addr_first", irom.addr, c_BOOT);
    repeat (10) tick();

    // Hold the fetch packet under stall.
    begin
      int n;
      n = 0;
      while (!if_valid && n < 20) begin
        tick();
        n++;
      end
    end
    stall     = 1'b1;
    hold_pc   = if_pc;
    hold_inst = if_inst;
    repeat (5) begin
      tick();
      check("stall_valid", {31'd0, if_valid}, 32'd1);
      check("stall_pc", if_pc, hold_pc);
      check("stall_inst", if_inst, hold_inst);
      check("stall_req", {31'd0, irom.req}, 32'd0);
    end
    stall = 1'b0;
    wait_grant();
    check("stall_resume", last_addr, hold_pc + 32'd4);
    repeat (4) tick();

    // Redirect while waiting for a response two cycles out.
    lat = 3;
    wait_grant();
    redirect(32'h1c00_0100);
    wait_grant();
    check("resp_redir_addr", last_addr, 32'h1c00_0100);
    repeat (6) tick();

    // Redirect in the same cycle as rvalid.
    lat = 1;
    wait_grant();
    redirect(32'h1c00_0300);
    wait_grant();
    check("rv_redir_addr", last_addr, 32'h1c00_0300);
    repeat (4) tick();

    // br_taken without br_valid is ignored.
    br_valid  = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h1c00_0900;
    repeat (6) tick();
    br_taken  = 1'b0;

    // Redirect coincident with a grant: the old grant is not honoured.
    wait_grant();
    tick();
`ifdef PC_GEN_ADEF_CHECK_EN
    redirect(32'h1c00_0404);
`else
    redirect(32'h1c00_0406);
`endif
    wait_grant();
    check("gnt_redir_addr", last_addr, 32'h1c00_0404);
    repeat (4) tick();

    // PC wraps at the top of the address space.
    redirect(32'hffff_fff8);
    wait_grant();
    check("wrap0", last_addr, 32'hffff_fff8);
    wait_grant();
    check("wrap1", last_addr, 32'hffff_fffc);
    wait_grant();
    check("wrap2", last_addr, 32'h0000_0000);
    repeat (3) tick();

    // Asynchronous reset with a request outstanding; stale rvalid in IDLE.
    lat = 3;
    wait_grant();
    #2;
    rstn = 1'b0;
    #1;
    check("arst_valid", {31'd0, if_valid}, 32'd0);
    check("arst_req", {31'd0, irom.req}, 32'd0);
    check("arst_pc", if_pc, 32'd0);
    sb.delete();
    mem_pend = 1'b0;
    mem_kill = 1'b0;
    exp_next = c_BOOT;
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    stale_inj = 1'b1;
    tick();
    check("stale_ignored", {31'd0, if_valid}, 32'd0);
    lat = 1;
    wait_grant();
    check("post_rst_addr", last_addr, c_BOOT);
    repeat (6) tick();

`ifdef PC_GEN_ADEF_CHECK_EN
    begin
      int n;
      n = 0;
      while (mem_pend && n < 20) begin
        tick();
        n++;
      end
    end
    redirect(32'h1c00_0102);
    check("adef_set", {31'd0, adef}, 32'd1);
    repeat (5) begin
      tick();
      check("adef_no_req", {31'd0, irom.req}, 32'd0);
    end
    redirect(32'h1c00_0200);
    check("adef_clr", {31'd0, adef}, 32'd0);
    wait_grant();
    check("adef_resume", last_addr, 32'h1c00_0200);
    repeat (4) tick();
`endif

    // Drain: no new grants, every returned word must reach decode.
    gnt_en = 1'b0;
    repeat (8) tick();
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
